packer_10_16: RTL and testbench

- Width converter from 10-bit words to 16-bit words: the transmit-side counterpart of the 16-to-10 unpacker. Accepts a stream of 10-bit words and packs them LSB-first, with no gaps, into 16-bit words.
- 8 input words produce exactly 5 output words (80 bits). Valid/ready handshake on both sides, plus a flush that emits a zero-padded partial word.

---
 rtl/packer_10_16.sv | 83 ++++++++
 tb/tb_packer_10_16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/packer_10_16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// packer_10_16 : packs a 10-bit word stream LSB-first into 16-bit words.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module packer_10_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        aligned
);

  localparam logic [3:0] C_FILL_LIMIT = 4'd6;

  logic [15:0] acc_q, acc_d;
  logic [3:0]  fill_q, fill_d;
  logic [15:0] out_q, out_d;
  logic        ov_q, ov_d;

  logic        w_out_free;
  logic        w_accept;
  logic [25:0] w_merged;
  logic [15:0] w_fill_mask;

  assign w_out_free  = !ov_q || out_ready;
  assign in_ready    = !rst && !flush && ((fill_q < C_FILL_LIMIT) || w_out_free);
  assign w_accept    = in_valid && in_ready;
  assign w_merged    = {10'd0, acc_q} | ({16'd0, in_data} << fill_q);
  assign w_fill_mask = (16'd1 << fill_q) - 16'd1;

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    out_d  = out_q;
    ov_d   = ov_q;
    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
    if (w_accept) begin
      if (fill_q < C_FILL_LIMIT) begin
        acc_d  = w_merged[15:0];
        fill_d = fill_q + 4'd10;
      end else begin
        // Word completes: low 16 bits leave, the carry becomes the new pending bits.
        out_d  = w_merged[15:0];
        ov_d   = 1'b1;
        acc_d  = {6'd0, w_merged[25:16]};
        fill_d = fill_q - C_FILL_LIMIT;
      end
    end else if (flush && (fill_q != 4'd0) && w_out_free) begin
      out_d  = acc_q & w_fill_mask;
      ov_d   = 1'b1;
      acc_d  = 16'd0;
      fill_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 16'd0;
      fill_q <= 4'd0;
      out_q  <= 16'd0;
      ov_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      ov_q   <= ov_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign aligned   = (fill_q == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_packer_10_16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_packer_10_16 : directed bench for packer_10_16.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_packer_10_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  in_data = 10'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        aligned;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] got[$];

  packer_10_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aligned   (aligned)
  );

  always #5 clk = ~clk;

  // Words handed over at the coming edge are recorded mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [9:0] w, output int waits);
    in_data  = w;
    in_valid = 1'b1;
    waits    = 0;
    #1;
    while (!in_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] ramp_exp [5];
  int w, wsum;

  initial begin
    ramp_exp[0] = 16'h0801; ramp_exp[1] = 16'h0030; ramp_exp[2] = 16'h0501;
    ramp_exp[3] = 16'h7018; ramp_exp[4] = 16'h0200;

    // Reset state
    idle(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_aligned", {31'd0, aligned}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Ramp, no stall
    got.delete();
    wsum = 0;
    for (int i = 1; i <= 8; i++) begin
      send(i[9:0], w);
      wsum += w;
    end
    chk("ramp_aligned", {31'd0, aligned}, 32'd1);
    idle(2);
    chk("ramp_no_stall", wsum, 32'd0);
    chk("ramp_count", got.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk("ramp_word", {16'd0, got[i]}, {16'd0, ramp_exp[i]});

    // Pattern, then flush out the 4 leftover bits
    got.delete();
    send(10'h155, w);
    send(10'h2AA, w);
    chk("pat_word", {16'd0, out_data}, 32'h0000A955);
    chk("pat_not_aligned", {31'd0, aligned}, 32'd0);
    idle(1);
    flush = 1'b1;
    #1;
    chk("flush_blocks_input", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("pat_flush_data", {16'd0, out_data}, 32'h0000000A);
    chk("pat_flush_aligned", {31'd0, aligned}, 32'd1);
    idle(2);
    chk("pat_count", got.size(), 32'd2);

    // All ones
    got.delete();
    for (int i = 1; i <= 16; i++) begin
      send(10'h3FF, w);
      if (i == 8 || i == 16) chk("ones_aligned", {31'd0, aligned}, 32'd1);
    end
    idle(2);
    chk("ones_count", got.size(), 32'd10);
    for (int i = 0; i < got.size(); i++) chk("ones_word", {16'd0, got[i]}, 32'h0000FFFF);

    // Backpressure
    got.delete();
    send(10'd1, w);
    send(10'd2, w);
    out_ready = 1'b0;
    send(10'd3, w);
    chk("bp_w2_accepted", w, 32'd0);
    in_data  = 10'd4;
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", {16'd0, out_data}, 32'h00000801);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 4; i <= 8; i++) send(i[9:0], w);
    idle(2);
    chk("bp_count", got.size(), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk("bp_word", {16'd0, got[i]}, {16'd0, ramp_exp[i]});

    // Flush of a single word, then flush with nothing pending
    send(10'h3FF, w);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_data", {16'd0, out_data}, 32'h000003FF);
    chk("flush_aligned", {31'd0, aligned}, 32'd1);
    idle(2);
    got.delete();
    flush = 1'b1;
    idle(2);
    flush = 1'b0;
    idle(2);
    chk("flush_empty_count", got.size(), 32'd0);
    chk("flush_empty_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-group
    send(10'd1, w);
    send(10'd2, w);
    send(10'd3, w);
    rst = 1'b1;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {16'd0, out_data}, 32'd0);
    chk("midrst_aligned", {31'd0, aligned}, 32'd1);
    rst = 1'b0;
    idle(1);
    got.delete();
    for (int i = 1; i <= 8; i++) send(i[9:0], w);
    idle(2);
    chk("midrst_count", got.size(), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk("midrst_word", {16'd0, got[i]}, {16'd0, ramp_exp[i]});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
